// File: rtl/uart_tx_typed_chunk_encoder_pkg.sv
// Frame constants and FSM state encoding for the typed-chunk encoder.
// The receiver imports the same package.
package uart_tx_typed_chunk_encoder_pkg;

    localparam logic [7:0] CHUNK_START = 8'h00;
    localparam logic [7:0] CHUNK_ESC   = 8'h00;
    localparam logic [7:0] CHUNK_END   = 8'h01;

    // Values are fixed so that both ends of the link decode state dumps alike.
    typedef enum logic [3:0] {
        ST_IDLE          = 4'd0,
        ST_SEND_START    = 4'd1,
        ST_SEND_TYPE     = 4'd2,
        ST_SEND_BYTE     = 4'd3,
        ST_SEND_NULL_ESC = 4'd4,
        ST_SEND_END_ESC  = 4'd5,
        ST_SEND_END      = 4'd6,
        ST_DONE          = 4'd7,
        ST_ERROR         = 4'd8
    } chunk_state_e;

    function automatic logic is_send_state(input chunk_state_e s);
        return s inside {ST_SEND_START, ST_SEND_TYPE, ST_SEND_BYTE,
                         ST_SEND_NULL_ESC, ST_SEND_END_ESC, ST_SEND_END};
    endfunction

endpackage

// File: rtl/uart_tx_typed_chunk_encoder_handshake.sv
// Per-byte handshake with the UART TX core: one start pulse on entry to a
// send state, then wait for tx_done before allowing the FSM to advance.
module uart_tx_byte_handshake (
    input  logic clk_i,
    input  logic rst_i,
    input  logic send_i,
    input  logic tx_done_i,
    output logic tx_start_o,
    output logic advance_o
);

    logic wait_q;
    logic wait_d;

    always_comb begin
        tx_start_o = send_i & ~wait_q;
        // tx_done outside the waiting window (including the start cycle) is dropped.
        advance_o  = send_i & wait_q & tx_done_i;
        wait_d     = wait_q;
        if (!send_i || advance_o) begin
            wait_d = 1'b0;
        end else if (tx_start_o) begin
            wait_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_q <= 1'b0;
        end else begin
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/uart_tx_typed_chunk_encoder.sv
// Serialises one typed payload chunk into an escaped byte stream:
// 00, type, payload (00 doubled), 00 01.
module uart_tx_typed_chunk_encoder
    import uart_tx_typed_chunk_encoder_pkg::*;
#(
    parameter int CONTENT_BUFFER_BYTE_SIZE = 3,
    parameter int BYTE_COUNT_WIDTH         = 8
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [7:0]                            chunk_type,
    input  logic [CONTENT_BUFFER_BYTE_SIZE*8-1:0] chunk_bytes,
    input  logic [BYTE_COUNT_WIDTH-1:0]           chunk_byte_size,
    input  logic                                  is_chunk_valid,
    output logic                                  is_encoder_ready,
    output logic                                  is_chunk_sent,
    output logic                                  is_chunk_error,
    output logic [7:0]                            tx_data,
    output logic                                  is_tx_start,
    input  logic                                  is_tx_done
);

    localparam logic [BYTE_COUNT_WIDTH-1:0] SIZE_MAX =
        BYTE_COUNT_WIDTH'(CONTENT_BUFFER_BYTE_SIZE);

    chunk_state_e state_q;
    chunk_state_e state_d;
    logic [BYTE_COUNT_WIDTH-1:0] idx_q;
    logic [BYTE_COUNT_WIDTH-1:0] idx_d;
    logic [BYTE_COUNT_WIDTH-1:0] idx_next;

    logic [7:0]                            type_q;
    logic [CONTENT_BUFFER_BYTE_SIZE*8-1:0] bytes_q;
    logic [BYTE_COUNT_WIDTH-1:0]           size_q;

    logic       accept;
    logic       send_active;
    logic       advance;
    logic [7:0] cur_byte;

    assign accept      = is_chunk_valid && (state_q == ST_IDLE);
    assign send_active = is_send_state(state_q);
    assign idx_next    = idx_q + 1'b1;
    assign cur_byte    = bytes_q[{idx_q, 3'b000} +: 8];

    uart_tx_byte_handshake u_handshake (
        .clk_i      (CLK),
        .rst_i      (RST),
        .send_i     (send_active),
        .tx_done_i  (is_tx_done),
        .tx_start_o (is_tx_start),
        .advance_o  (advance)
    );

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        is_encoder_ready = (state_q == ST_IDLE);
        is_chunk_sent    = (state_q == ST_DONE);
        is_chunk_error   = (state_q == ST_ERROR);
        case (state_q)
            ST_IDLE: begin
                if (is_chunk_valid) begin
                    idx_d = '0;
                    // Deciding on the live inputs equals deciding on the values latched this edge.
                    if (chunk_type == 8'h00 || chunk_byte_size > SIZE_MAX) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_SEND_START;
                    end
                end
            end
            ST_SEND_START: begin
                if (advance) state_d = ST_SEND_TYPE;
            end
            ST_SEND_TYPE: begin
                if (advance) state_d = (size_q != '0) ? ST_SEND_BYTE : ST_SEND_END_ESC;
            end
            ST_SEND_BYTE: begin
                if (advance) begin
                    if (cur_byte == CHUNK_ESC) begin
                        state_d = ST_SEND_NULL_ESC;
                    end else begin
                        idx_d   = idx_next;
                        state_d = (idx_next < size_q) ? ST_SEND_BYTE : ST_SEND_END_ESC;
                    end
                end
            end
            ST_SEND_NULL_ESC: begin
                if (advance) begin
                    idx_d   = idx_next;
                    state_d = (idx_next < size_q) ? ST_SEND_BYTE : ST_SEND_END_ESC;
                end
            end
            ST_SEND_END_ESC: begin
                if (advance) state_d = ST_SEND_END;
            end
            ST_SEND_END: begin
                if (advance) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // tx_data depends only on registered state, so it holds while waiting for tx_done.
    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            ST_SEND_START:    tx_data = CHUNK_START;
            ST_SEND_TYPE:     tx_data = type_q;
            ST_SEND_BYTE:     tx_data = cur_byte;
            ST_SEND_NULL_ESC: tx_data = CHUNK_ESC;
            ST_SEND_END_ESC:  tx_data = CHUNK_ESC;
            ST_SEND_END:      tx_data = CHUNK_END;
            default:          tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            type_q  <= chunk_type;
            bytes_q <= chunk_bytes;
            size_q  <= chunk_byte_size;
        end
    end

endmodule

// File: tb/tb_uart_tx_typed_chunk_encoder.sv
// Bench for uart_tx_typed_chunk_encoder: a randomized UART TX responder
// checked against a frame-level model of the escaped byte stream.
module tb_uart_tx_typed_chunk_encoder;

    localparam int N = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  chunk_type = 8'h00;
    logic [N*8-1:0] chunk_bytes = '0;
    logic [7:0]  chunk_byte_size = 8'h00;
    logic        is_chunk_valid = 1'b0;
    logic        is_encoder_ready;
    logic        is_chunk_sent;
    logic        is_chunk_error;
    logic [7:0]  tx_data;
    logic        is_tx_start;
    logic        is_tx_done = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    bit         exp_err;

    uart_tx_typed_chunk_encoder #(
        .CONTENT_BUFFER_BYTE_SIZE (N),
        .BYTE_COUNT_WIDTH         (8)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .chunk_type       (chunk_type),
        .chunk_bytes      (chunk_bytes),
        .chunk_byte_size  (chunk_byte_size),
        .is_chunk_valid   (is_chunk_valid),
        .is_encoder_ready (is_encoder_ready),
        .is_chunk_sent    (is_chunk_sent),
        .is_chunk_error   (is_chunk_error),
        .tx_data          (tx_data),
        .is_tx_start      (is_tx_start),
        .is_tx_done       (is_tx_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Frame model: what must appear on the wire for a given request.
    task automatic build_model(input logic [7:0] t, input logic [N*8-1:0] b, input logic [7:0] sz);
        logic [7:0] v;
        exp_q.delete();
        exp_err = (t == 8'h00) || (sz > 8'(N));
        if (!exp_err) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(t);
            for (int i = 0; i < int'(sz); i++) begin
                v = b[i*8 +: 8];
                exp_q.push_back(v);
                if (v == 8'h00) exp_q.push_back(8'h00);
            end
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h01);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, is_encoder_ready, 1);
        chk({tag, "_start"}, is_tx_start, 0);
        chk({tag, "_data"},  tx_data, 0);
        chk({tag, "_sent"},  is_chunk_sent, 0);
        chk({tag, "_err"},   is_chunk_error, 0);
    endtask

    task automatic run_frame(input logic [7:0] t, input logic [N*8-1:0] b, input logic [7:0] sz,
                             input bit tog, input int abort_k);
        int k, delay;
        bit waiting, want_start, start_next, sent_due, fin, aborted;
        logic [7:0] held;
        build_model(t, b, sz);
        chk("ready_before", is_encoder_ready, 1);
        chunk_type      = t;
        chunk_bytes     = b;
        chunk_byte_size = sz;
        is_chunk_valid  = 1'b1;
        step();
        is_chunk_valid  = 1'b0;
        if (exp_err) begin
            chk("err_pulse", is_chunk_error, 1);
            chk("err_no_start", is_tx_start, 0);
            chk("err_busy", is_encoder_ready, 0);
            step();
            chk("err_clear", is_chunk_error, 0);
            chk("err_ready", is_encoder_ready, 1);
            chk("err_no_start2", is_tx_start, 0);
            return;
        end
        k = 0; delay = 0; waiting = 0; start_next = 1; sent_due = 0;
        fin = 0; aborted = 0; held = 8'h00;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            want_start = start_next;
            start_next = 0;
            is_tx_done = 1'b0;
            if (tog) begin
                chunk_type      = 8'($urandom);
                chunk_bytes     = N*8'($urandom);
                chunk_byte_size = 8'($urandom_range(0, 5));
                is_chunk_valid  = 1'($urandom);
            end
            chk("no_err", is_chunk_error, 0);
            if (sent_due) begin
                chk("sent_pulse", is_chunk_sent, 1);
                chk("sent_busy", is_encoder_ready, 0);
                chk("sent_no_start", is_tx_start, 0);
                fin = 1;
            end else begin
                chk("sent_quiet", is_chunk_sent, 0);
                chk("busy", is_encoder_ready, 0);
                if (want_start) chk("start_timing", is_tx_start, 1);
                if (is_tx_start) begin
                    chk("start_allowed", {31'b0, waiting || (k >= exp_q.size())}, 0);
                    if (!waiting && k < exp_q.size()) begin
                        chk("byte", tx_data, exp_q[k]);
                        held    = tx_data;
                        k++;
                        waiting = 1;
                        delay   = $urandom_range(1, 50);
                        if ($urandom_range(0, 3) == 0) is_tx_done = 1'b1;
                        if (k == abort_k) begin
                            #2 RST = 1'b1;
                            #1;
                            check_reset_outputs("rst_async");
                            is_tx_done     = 1'b0;
                            is_chunk_valid = 1'b0;
                            step();
                            check_reset_outputs("rst_held");
                            RST = 1'b0;
                            step();
                            chk("rst_release_ready", is_encoder_ready, 1);
                            chk("rst_release_start", is_tx_start, 0);
                            fin = 1;
                            aborted = 1;
                        end
                    end
                end else if (waiting) begin
                    chk("hold", tx_data, held);
                    delay--;
                    if (delay == 0) begin
                        is_tx_done = 1'b1;
                        waiting = 0;
                        if (k == exp_q.size()) sent_due = 1;
                        else start_next = 1;
                    end
                end
            end
            if (fin) is_chunk_valid = 1'b0;
            if (!fin) step();
        end
        chk("frame_finished", {31'b0, fin}, 1);
        if (fin && !aborted) begin
            is_tx_done = 1'b0;
            step();
            chk("ready_after", is_encoder_ready, 1);
            chk("sent_once", is_chunk_sent, 0);
            chk("wire_len", k, exp_q.size());
        end
        is_tx_done = 1'b0;
    endtask

    logic [7:0] lit1 [7];
    logic [7:0] lit2 [9];
    logic [7:0] lit3 [4];

    initial begin
        lit1 = '{8'h00, 8'h05, 8'h11, 8'h22, 8'h33, 8'h00, 8'h01};
        lit2 = '{8'h00, 8'h07, 8'h00, 8'h00, 8'h41, 8'h00, 8'h00, 8'h00, 8'h01};
        lit3 = '{8'h00, 8'h09, 8'h00, 8'h01};

        #1;
        check_reset_outputs("reset");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        step();
        check_reset_outputs("post_reset");

        build_model(8'h05, 24'h332211, 8'd3);
        chk("model1_len", exp_q.size(), 7);
        for (int i = 0; i < 7; i++) chk("model1_byte", exp_q[i], lit1[i]);
        build_model(8'h07, 24'h004100, 8'd3);
        chk("model2_len", exp_q.size(), 9);
        for (int i = 0; i < 9; i++) chk("model2_byte", exp_q[i], lit2[i]);
        build_model(8'h09, 24'h000000, 8'd0);
        chk("model3_len", exp_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("model3_byte", exp_q[i], lit3[i]);
        build_model(8'h00, 24'h010101, 8'd1);
        chk("model_rej_type", {31'b0, exp_err}, 1);
        build_model(8'h05, 24'h010101, 8'd4);
        chk("model_rej_size", {31'b0, exp_err}, 1);

        run_frame(8'h05, 24'h332211, 8'd3, 1'b0, 0);
        run_frame(8'h07, 24'h004100, 8'd3, 1'b0, 0);
        run_frame(8'h09, 24'h000000, 8'd0, 1'b0, 0);
        run_frame(8'h00, 24'h112233, 8'd2, 1'b0, 0);
        run_frame(8'h05, 24'h112233, 8'd4, 1'b0, 0);
        run_frame(8'h5A, 24'h00AB00, 8'd3, 1'b1, 2);
        run_frame(8'h33, 24'h010203, 8'd3, 1'b1, 0);

        for (int f = 0; f < 40; f++) begin
            logic [7:0] t, sz;
            logic [N*8-1:0] b;
            t  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            sz = 8'($urandom_range(0, 4));
            for (int i = 0; i < N; i++)
                b[i*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            run_frame(t, b, sz, 1'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
